// File: rtl/pixel_framebuffer_if.sv
// -----------------------------------------------------------------------------
// pixel_framebuffer_if
//   Pixel-plot bus between the drawing/processor FSMs and the frame buffer.
//
//   master (drawing side): drives x_in, y_in, color_in, plot, clear;
//                          receives busy, dropped
//   slave  (frame buffer): receives x_in, y_in, color_in, plot, clear;
//                          drives busy, dropped
//
//   x_in     [7:0]  plot x coordinate
//   y_in     [6:0]  plot y coordinate
//   color_in [2:0]  plot colour
//   plot            write strobe, one pixel per cycle while high
//   clear           request a full-screen clear sweep
//   busy            clear sweep in progress
//   dropped         one-cycle pulse: the previous cycle's plot was discarded
// -----------------------------------------------------------------------------
interface pixel_framebuffer_if;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] color_in;
   logic       plot;
   logic       clear;
   logic       busy;
   logic       dropped;

   modport master (
      output x_in, y_in, color_in, plot, clear,
      input  busy, dropped
   );

   modport slave (
      input  x_in, y_in, color_in, plot, clear,
      output busy, dropped
   );
endinterface

// File: rtl/pixel_framebuffer.sv
// -----------------------------------------------------------------------------
// pixel_framebuffer
//   Stores plotted pixels in a WIDTH x HEIGHT x 3-bit frame store and scans it
//   out continuously as a raster stream with sync pulses. A hardware clear
//   sweep writes BG_COLOR to every location, one per clock.
//
//   clk          clock
//   resetn       synchronous, active-low reset
//   bus          pixel-plot bus (slave side): x_in, y_in, color_in, plot,
//                clear in; busy, dropped out
//   pix_color    scanned-out pixel colour (0 outside the active area)
//   pix_valid    pix_color belongs to the active area
//   hsync_n      horizontal sync, active low
//   vsync_n      vertical sync, active low
//   frame_start  one-cycle pulse marking pixel (0,0) on the output
// -----------------------------------------------------------------------------
module pixel_framebuffer #(
   parameter int          WIDTH        = 160,
   parameter int          HEIGHT       = 120,
   parameter int          H_TOTAL      = 200,
   parameter int          V_TOTAL      = 130,
   parameter int          H_SYNC_START = 168,
   parameter int          H_SYNC_LEN   = 16,
   parameter int          V_SYNC_START = 122,
   parameter int          V_SYNC_LEN   = 2,
   parameter logic [2:0]  BG_COLOR     = 3'b000
) (
   input  logic                clk,
   input  logic                resetn,
   pixel_framebuffer_if.slave  bus,
   output logic [2:0]          pix_color,
   output logic                pix_valid,
   output logic                hsync_n,
   output logic                vsync_n,
   output logic                frame_start
);

   localparam int NPIX   = WIDTH * HEIGHT;
   // Memory address width; 15 bits at the default 160x120 geometry.
   localparam int MEM_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int H_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

   state_t              r_state, w_state_next;
   logic [MEM_AW-1:0]   r_sweep_addr;
   logic                r_dropped;

   logic                w_in_range;
   logic [MEM_AW-1:0]   w_plot_addr;
   logic                w_we;
   logic [MEM_AW-1:0]   w_waddr;
   logic [2:0]          w_wdata;

   // ---------------------------------------------------------------- write side
   // Products are formed at 32 bits so y*WIDTH+x never truncates before the
   // result is narrowed to the memory address width.
   assign w_in_range  = (32'(bus.x_in) < WIDTH) && (32'(bus.y_in) < HEIGHT);
   assign w_plot_addr = MEM_AW'(32'(bus.y_in) * WIDTH + 32'(bus.x_in));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         // Plots are discarded while sweeping or when off-screen.
         r_dropped <= bus.plot && ((r_state == S_CLEAR) || !w_in_range);
      end
   end

   // Sweep address is held at 0 while idle so every sweep starts at 0.
   always_ff @(posedge clk) begin
      if (!resetn || r_state == S_IDLE) begin
         r_sweep_addr <= '0;
      end else begin
         r_sweep_addr <= r_sweep_addr + MEM_AW'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_we         = 1'b0;
      w_waddr      = w_plot_addr;
      w_wdata      = bus.color_in;
      case (r_state)
         S_IDLE: begin
            // A plot in the same cycle as clear still lands; the sweep
            // overwrites it afterwards.
            w_we = bus.plot && w_in_range;
            if (bus.clear) begin
               w_state_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_sweep_addr;
            w_wdata = BG_COLOR;
            if (32'(r_sweep_addr) == NPIX - 1) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign bus.busy    = (r_state == S_CLEAR);
   assign bus.dropped = r_dropped;

   // ---------------------------------------------------------------- scan side
   logic [H_W-1:0]    r_h;
   logic [V_W-1:0]    r_v;
   logic              w_h_last, w_v_last, w_scan_valid;
   logic              w_hsync_act, w_vsync_act;
   logic [MEM_AW-1:0] w_raddr;

   assign w_h_last     = (32'(r_h) == H_TOTAL - 1);
   assign w_v_last     = (32'(r_v) == V_TOTAL - 1);
   assign w_scan_valid = (32'(r_h) < WIDTH) && (32'(r_v) < HEIGHT);
   assign w_hsync_act  = (32'(r_h) >= H_SYNC_START) &&
                         (32'(r_h) <  H_SYNC_START + H_SYNC_LEN);
   assign w_vsync_act  = (32'(r_v) >= V_SYNC_START) &&
                         (32'(r_v) <  V_SYNC_START + V_SYNC_LEN);
   // Blanking positions read address 0 so the read index stays in range;
   // the data is masked at the output anyway.
   assign w_raddr      = w_scan_valid ? MEM_AW'(32'(r_v) * WIDTH + 32'(r_h))
                                      : '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_h <= '0;
         r_v <= '0;
      end else begin
         r_h <= w_h_last ? '0 : r_h + H_W'(1);
         if (w_h_last) begin
            r_v <= w_v_last ? '0 : r_v + V_W'(1);
         end
      end
   end

   // Timing outputs are registered alongside the RAM read so all five outputs
   // share the same one-cycle delay from the counters.
   logic r_pix_valid, r_hsync_n, r_vsync_n, r_frame_start;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pix_valid   <= 1'b0;
         r_hsync_n     <= 1'b1;
         r_vsync_n     <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_valid   <= w_scan_valid;
         r_hsync_n     <= !w_hsync_act;
         r_vsync_n     <= !w_vsync_act;
         r_frame_start <= (r_h == '0) && (r_v == '0);
      end
   end

   // ------------------------------------------------------------ frame store
   // Simple dual-port RAM: one write port, one registered read port. Both
   // use non-blocking updates in one process, giving read-first behaviour on
   // a same-address collision. Contents are intentionally not reset.
   logic [2:0] mem [0:NPIX-1];
   logic [2:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (w_we) begin
         mem[w_waddr] <= w_wdata;
      end
      r_rd_data <= mem[w_raddr];
   end

   // r_rd_data is not reset; masking with the valid flag keeps pix_color at 0
   // out of reset and during blanking.
   assign pix_color   = r_pix_valid ? r_rd_data : 3'b000;
   assign pix_valid   = r_pix_valid;
   assign hsync_n     = r_hsync_n;
   assign vsync_n     = r_vsync_n;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_framebuffer
//   Directed self-checking bench for pixel_framebuffer on a small 8x4 raster
//   (12 clocks per line, 6 lines per frame, 72 clocks per frame).
// -----------------------------------------------------------------------------
module tb_pixel_framebuffer;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int HT    = 12;
   localparam int VT    = 6;
   localparam int HSS   = 9;
   localparam int HSL   = 2;
   localparam int VSS   = 4;
   localparam int VSL   = 1;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] pix_color;
   logic       pix_valid, hsync_n, vsync_n, frame_start;

   pixel_framebuffer_if bus();

   pixel_framebuffer #(
      .WIDTH(W), .HEIGHT(H), .H_TOTAL(HT), .V_TOTAL(VT),
      .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .BG_COLOR(3'b000)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .pix_color   (pix_color),
      .pix_valid   (pix_valid),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
         $display("check %-18s got %0d expected %0d ok", tag, obs, exp_v);
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_plot(input int x, input int y, input int c);
      bus.x_in     = 8'(x);
      bus.y_in     = 7'(y);
      bus.color_in = 3'(c);
      bus.plot     = 1'b1;
   endtask

   // Counts consecutive busy-high samples, starting with the current one.
   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   // Aligns to the next frame_start and checks one whole frame of colours:
   // pc at (px,py), 0 at every other output position.
   task automatic check_frame(input string tag, input int px, input int py,
                              input int pc);
      int waited = 0;
      int errs   = 0;
      while (frame_start !== 1'b1 && waited < 2 * FRAME) begin
         tick();
         waited++;
      end
      check({tag, "_sync"}, 32'(frame_start), 32'd1);
      for (int k = 0; k < FRAME; k++) begin
         int h = k % HT;
         int v = k / HT;
         int exp_c = (h < W && v < H && h == px && v == py) ? pc : 0;
         if (pix_color !== 3'(exp_c)) errs++;
         tick();
      end
      check(tag, 32'(errs), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int errs, fs_cnt, fs_first, fs_second, val_cnt, hs_cnt, vs_cnt;

      bus.x_in     = '0;
      bus.y_in     = '0;
      bus.color_in = '0;
      bus.plot     = 1'b0;
      bus.clear    = 1'b0;
      resetn       = 1'b0;
      repeat (3) tick();

      check("rst_busy",        32'(bus.busy),    32'd0);
      check("rst_dropped",     32'(bus.dropped), 32'd0);
      check("rst_pix_color",   32'(pix_color),   32'd0);
      check("rst_pix_valid",   32'(pix_valid),   32'd0);
      check("rst_hsync_n",     32'(hsync_n),     32'd1);
      check("rst_vsync_n",     32'(vsync_n),     32'd1);
      check("rst_frame_start", 32'(frame_start), 32'd0);

      // Two frames of raster timing. Output sample k reflects counter
      // position k: h = k%12, v = (k/12)%6.
      resetn = 1'b1;
      errs = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
      val_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         int h, v;
         logic e_val, e_hs, e_vs, e_fs;
         tick();
         h = k % HT;
         v = (k / HT) % VT;
         e_val = (h < W) && (v < H);
         e_hs  = !((h >= HSS) && (h < HSS + HSL));
         e_vs  = !((v >= VSS) && (v < VSS + VSL));
         e_fs  = (h == 0) && (v == 0);
         if (pix_valid !== e_val || hsync_n !== e_hs ||
             vsync_n !== e_vs || frame_start !== e_fs) errs++;
         if (frame_start === 1'b1) begin
            if (fs_cnt == 0) fs_first = k; else fs_second = k;
            fs_cnt++;
         end
         if (pix_valid === 1'b1) val_cnt++;
         if (hsync_n === 1'b0)   hs_cnt++;
         if (vsync_n === 1'b0)   vs_cnt++;
      end
      check("scan_pattern",   32'(errs),      32'd0);
      check("fs_count",       32'(fs_cnt),    32'd2);
      check("fs_first",       32'(fs_first),  32'd0);
      check("fs_period",      32'(fs_second), 32'd72);
      check("valid_count",    32'(val_cnt),   32'd64);
      check("hsync_low",      32'(hs_cnt),    32'd24);
      check("vsync_low",      32'(vs_cnt),    32'd24);

      // Clear sweep, then an all-background frame.
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      count_busy(n);
      check("busy_len", 32'(n), 32'd32);
      check_frame("clear_frame", -1, -1, 0);

      // Single in-range plot.
      drive_plot(3, 2, 5);
      tick();
      bus.plot = 1'b0;
      check("drop_inrange", 32'(bus.dropped), 32'd0);
      check_frame("plot_frame", 3, 2, 5);

      // Out-of-range plots: x=8 would alias to (0,2), y=4 to (0,0) if stored.
      drive_plot(8, 1, 7);
      tick();
      bus.plot = 1'b0;
      check("drop_x", 32'(bus.dropped), 32'd1);
      tick();
      check("drop_pulse_len", 32'(bus.dropped), 32'd0);
      drive_plot(0, 4, 7);
      tick();
      bus.plot = 1'b0;
      check("drop_y", 32'(bus.dropped), 32'd1);
      check_frame("oor_frame", 3, 2, 5);

      // Plot at sweep cycle 5 is dropped; a re-clear at cycle 10 is ignored.
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         if (n == 5) drive_plot(1, 1, 7);
         if (n == 6) begin
            bus.plot = 1'b0;
            check("drop_busy", 32'(bus.dropped), 32'd1);
         end
         if (n == 10) bus.clear = 1'b1;
         if (n == 11) bus.clear = 1'b0;
         tick();
      end
      check("busy_len_reclear", 32'(n), 32'd32);
      check_frame("sweep_frame", -1, -1, 0);

      // Plot and clear in the same idle cycle: the sweep wins.
      drive_plot(5, 3, 6);
      bus.clear = 1'b1;
      tick();
      bus.plot  = 1'b0;
      bus.clear = 1'b0;
      check("drop_plot_clear", 32'(bus.dropped), 32'd0);
      count_busy(n);
      check("busy_len_pc", 32'(n), 32'd32);
      check_frame("pc_frame", -1, -1, 0);

      // Reset at sweep cycle 10 aborts the sweep; (6,3) = address 30 was
      // not yet reached so its colour survives.
      drive_plot(6, 3, 4);
      tick();
      bus.plot  = 1'b0;
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      n = 1;
      while (n < 10) begin
         tick();
         n++;
      end
      check("busy_at_cycle10", 32'(bus.busy), 32'd1);
      resetn = 1'b0;
      tick();
      check("busy_after_reset",  32'(bus.busy),    32'd0);
      check("valid_after_reset", 32'(pix_valid),   32'd0);
      check("fs_during_reset",   32'(frame_start), 32'd0);
      resetn = 1'b1;
      tick();
      check("fs_restart", 32'(frame_start), 32'd1);
      check("busy_stays_low", 32'(bus.busy), 32'd0);
      check_frame("retain_frame", 6, 3, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
Receiving end of the pixel-plot interface (x, y, color, writeEn) driven by the drawing/processor FSMs. It stores plotted pixels in a WIDTH x HEIGHT x 3-bit frame store and continuously scans the store out as a raster pixel stream with sync pulses for the display driver. It also provides a hardware clear sweep so the game logic can wipe the screen without issuing per-pixel erase writes.

Parameters:
WIDTH, 160, active pixels per line; x range 0..WIDTH-1
HEIGHT, 120, active lines per frame; y range 0..HEIGHT-1
H_TOTAL, 200, scan clocks per line, including blanking; must be greater than WIDTH
V_TOTAL, 130, lines per frame, including blanking; must be greater than HEIGHT
H_SYNC_START, 168, h count at which hsync_n is first asserted
H_SYNC_LEN, 16, hsync_n low width in clocks
V_SYNC_START, 122, v count at which vsync_n is first asserted
V_SYNC_LEN, 2, vsync_n low width in lines
BG_COLOR, 3'b000, colour written by the clear sweep

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
x_in  in  8  plot x coordinate
y_in  in  7  plot y coordinate
color_in  in  3  plot colour
plot  in  1  write strobe (writeEn from the drawing FSM); one pixel per cycle high
clear  in  1  request a full-screen clear sweep; sampled every cycle
busy  out  1  clear sweep in progress
dropped  out  1  one-cycle pulse: the plot in the previous cycle was discarded
pix_color  out  3  scanned-out pixel colour
pix_valid  out  1  pix_color is an active-area pixel
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
frame_start  out  1  one-cycle pulse marking pixel (0,0) on the output

Behaviour:
- Reset: busy=0, dropped=0, pix_color=0, pix_valid=0, hsync_n=1, vsync_n=1, frame_start=0. The h and v counters go to 0. The FSM goes to S_IDLE. Memory contents are not reset and are undefined until cleared or written.
- Reset asserted mid-sweep aborts the sweep. The partially cleared contents are retained and busy=0 on the next cycle.
- Addressing: addr = y*WIDTH + x, 15 bits, computed without truncation.
- Write port, S_IDLE only:
  - A plot with x_in<WIDTH and y_in<HEIGHT writes color_in at that clock edge.
  - An out-of-range plot is not written. dropped=1 on the next cycle.
- FSM states are S_IDLE and S_CLEAR.
- S_IDLE -> S_CLEAR on clear=1. busy=1 from the next cycle. The sweep address starts at 0.
- S_CLEAR:
  - Writes BG_COLOR to one address per cycle, ascending.
  - After writing address WIDTH*HEIGHT-1, returns to S_IDLE. busy=0 on the following cycle, so busy is high for exactly WIDTH*HEIGHT cycles.
  - Any plot while busy=1 is discarded, with dropped=1 on the next cycle.
  - clear while busy is ignored; it does not restart the sweep.
- plot and clear in the same S_IDLE cycle: the plot is performed and the sweep starts next cycle, so the plotted pixel is overwritten by the sweep.
- Scan counters:
  - h increments every clock and wraps from H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps from V_TOTAL-1 to 0.
  - The counters free-run independently of busy and of writes.
- Scan read is synchronous with 1-cycle latency. Counter value (h,v) at cycle N produces outputs at cycle N+1:
  - pix_valid = (h<WIDTH && v<HEIGHT).
  - pix_color = mem[v*WIDTH+h] if valid, else 0.
  - hsync_n = !(H_SYNC_START <= h < H_SYNC_START+H_SYNC_LEN).
  - vsync_n = !(V_SYNC_START <= v < V_SYNC_START+V_SYNC_LEN).
  - frame_start = (h==0 && v==0).
  - All five outputs are delayed identically.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-first). The new value is visible on the next scan of that address.
- Memory must infer as a simple dual-port RAM: one write port (plot or sweep, muxed by state) and one read port (scan).

Test Plan:
- Bench parameters: WIDTH=8, HEIGHT=4, H_TOTAL=12, V_TOTAL=6, H_SYNC_START=9, H_SYNC_LEN=2, V_SYNC_START=4, V_SYNC_LEN=1.
- Reset, then run 2 frames -> frame_start pulses exactly every 72 cycles. pix_valid high for 8 of every 12 clocks on lines 0-3. hsync_n low 2 clocks per line. vsync_n low for 12 clocks per frame.
- clear pulse, then idle -> busy high exactly 32 cycles. Next frame: all 32 active pixels read 3'b000.
- plot (3,2,3'b101) after clear -> next frame: pix_color=101 only at h=3,v=2, output one cycle after the counters hit (3,2). All other active pixels read 0.
- plot x=8,y=1 and plot x=0,y=4 -> dropped pulses on the cycle after each. No pixel changes.
- clear, then plot (1,1,3'b111) in cycle 5 of the sweep -> dropped=1. After the sweep, (1,1) reads 000. Second clear issued mid-sweep does not extend busy beyond 32 cycles.
- plot and clear in the same idle cycle -> the plotted pixel reads BG_COLOR after the sweep. resetn low at sweep cycle 10 -> busy=0 next cycle and scan counters restart at (0,0).
